seq_event_display: RTL and testbench
====================================

SEQ_EVENT_DISPLAY -- requirements
Module: seq_event_display

Interface
REQ-001 Parameter MODULUS, default 10: count modulus, legal range 2..16.
REQ-002 Parameter DP_HOLD, default 8: decimal-point stretch length in clk cycles, legal range 1..255.
REQ-003 clk  input  1  clock; all state SHALL change only on its rising edge, except for reset.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 det_in  input  1  detection level from the upstream sequence-detector stage; it may stay high for several cycles.
REQ-006 clr_in  input  1  synchronous clear of count, decimal-point timer and overflow.
REQ-007 hold_in  input  1  freezes the seg_out digit; counting continues.
REQ-008 seg_out  output  8  7-segment drive, active high: bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g, bit7=dp.
REQ-009 count_out  output  4  current event count, registered.
REQ-010 ovf_out  output  1  one-cycle pulse when the count wraps.

Function
REQ-011 Register det_in into det_q every cycle; an event SHALL be det_in=1 with det_q=0, giving one event per det_in assertion.
REQ-012 On an event, count SHALL increment at that same edge.
REQ-013 Count wrap: MODULUS-1 -> 0, with ovf_out=1 for exactly the cycle following the wrap edge; otherwise ovf_out=0.
REQ-014 clr_in=1 SHALL, at the next edge: force count=0, ovf_out=0 and the FSM to IDLE.
REQ-015 clr_in takes priority over a simultaneous event; that event SHALL be discarded.
REQ-016 FSM states IDLE and FLASH:
- IDLE -> FLASH on an event, loading timer=DP_HOLD.
- FLASH: timer decrements each cycle.
- FLASH -> IDLE when the timer reaches 1 with no event that cycle.
- An event in FLASH SHALL reload timer=DP_HOLD (retrigger).
REQ-017 seg_out[7] SHALL be 1 exactly while the FSM is in FLASH; seg_out[7] is unaffected by hold_in.
REQ-018 seg_out[6:0] SHALL be the registered decode of count, lagging count_out by one cycle. Decode values (gfedcba):
- 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
- 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
REQ-019 While hold_in=1, seg_out[6:0] SHALL retain its value; on hold_in falling, seg_out[6:0] SHALL show the current count one cycle later.
REQ-020 det_in held high across a clr_in SHALL NOT produce a new event until det_in falls and rises again.

Reset
REQ-021 reset=1 SHALL immediately force: count_out=0, ovf_out=0, FSM=IDLE, timer=0, seg_out=8'b00111111.
REQ-022 Reset SHALL force det_q=1, so a det_in level already high when reset releases is not counted.
REQ-023 Assertion of reset mid-FLASH SHALL abort the stretch, with no residual dp.

Structure
REQ-024 A shared package SHALL hold the 16-entry segment encoding constants, the FSM state typedef, and the DP_HOLD default.
REQ-025 The segment decode SHALL be a single combinational sub-module, seg7_hex_decode, reusable by the upstream stage.

Verification
REQ-026 Reset, then det_in 1 for 5 cycles -> exactly one event: count_out=1; seg_out[6:0]=0000110 one cycle later; dp high 8 cycles.
REQ-027 10 separate det_in pulses, MODULUS=10 -> count 9 -> 0; ovf_out one-cycle pulse; seg_out=0111111 after the wrap.
REQ-028 Second event 3 cycles after the first -> dp stays high continuously for 3+8=11 cycles total.
REQ-029 clr_in and a det_in rise in the same cycle -> count_out=0, no ovf, dp low; det_in held high -> no further count.
REQ-030 hold_in=1 from count 2, then 3 events -> seg_out[6:0] stays 1011011 while count_out=5; release -> 1101101 next cycle.
REQ-031 reset asserted mid-FLASH at count 4 -> seg_out=00111111 immediately; det_in high through reset release -> count stays 0.

Source files
------------

// File: rtl/seq_event_display_pkg.sv
// Shared definitions for the event counter / 7-segment display slice:
// hex segment encodings, flash FSM state type and default parameters.
package seq_event_display_pkg;

  localparam int MODULUS_DEFAULT = 10;
  localparam int DP_HOLD_DEFAULT = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } dp_state_e;

  // Active-high segments, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG7_HEX [16] = '{
    7'b0111111,  // 0
    7'b0000110,  // 1
    7'b1011011,  // 2
    7'b1001111,  // 3
    7'b1100110,  // 4
    7'b1101101,  // 5
    7'b1111101,  // 6
    7'b0000111,  // 7
    7'b1111111,  // 8
    7'b1101111,  // 9
    7'b1110111,  // A
    7'b1111100,  // b
    7'b0111001,  // C
    7'b1011110,  // d
    7'b1111001,  // E
    7'b1110001   // F
  };

endpackage

// File: rtl/seq_event_display_seg7_hex_decode.sv
// Purely combinational hex-to-7-segment decoder, shared with the
// upstream sequence-detector stage.
module seg7_hex_decode
  import seq_event_display_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  assign seg = SEG7_HEX[value];

endmodule

// File: rtl/seq_event_display.sv
// Counts rising edges of det_in modulo MODULUS, shows the count on a
// 7-segment digit and stretches each event into a DP_HOLD-cycle dp flash.
module seq_event_display
  import seq_event_display_pkg::*;
#(
  parameter int MODULUS = MODULUS_DEFAULT,
  parameter int DP_HOLD = DP_HOLD_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       det_in,
  input  logic       clr_in,
  input  logic       hold_in,
  output logic [7:0] seg_out,
  output logic [3:0] count_out,
  output logic       ovf_out
);

  localparam logic [3:0] COUNT_MAX = 4'(MODULUS - 1);
  localparam logic [7:0] HOLD_LOAD = 8'(DP_HOLD);

  logic       det_q;
  logic       det_event;
  logic [3:0] count_q;
  logic       ovf_q;
  dp_state_e  state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [6:0] digit_q, digit_d;
  logic       dp;

  assign det_event = det_in & ~det_q;

  // det_q resets high so a level already asserted at reset release is not an event.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      det_q   <= 1'b1;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      det_q <= det_in;
      if (clr_in) begin
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else begin
        ovf_q <= det_event && (count_q == COUNT_MAX);
        if (det_event) count_q <= (count_q == COUNT_MAX) ? 4'd0 : count_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // NOTE: defaults first so every path assigns state_d/timer_d and no latch is inferred.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (clr_in) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (det_event) begin
            state_d = FLASH;
            timer_d = HOLD_LOAD;
          end
        end
        FLASH: begin
          if (det_event) begin
            timer_d = HOLD_LOAD;
          end else if (timer_q == 8'd1) begin
            state_d = IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    dp = (state_q == FLASH);
  end

  seg7_hex_decode u_decode (
    .value (count_q),
    .seg   (digit_d)
  );

  // The digit register gives the one-cycle lag behind count_out and the hold freeze.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_q <= SEG7_HEX[0];
    end else if (!hold_in) begin
      digit_q <= digit_d;
    end
  end

  assign seg_out   = {dp, digit_q};
  assign count_out = count_q;
  assign ovf_out   = ovf_q;

endmodule

// File: tb/tb_seq_event_display.sv
// Directed scoreboard bench: the driver queues the expected post-edge state
// for every cycle it drives; a monitor pops and compares after each edge.
module tb_seq_event_display;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       det_in = 1'b0;
  logic       clr_in = 1'b0;
  logic       hold_in = 1'b0;
  logic [7:0] seg_out;
  logic [3:0] count_out;
  logic       ovf_out;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      name;
    int         cnt;   // -1 = not checked
    int         ovf;
    int         dp;
    int         seg7;
  } exp_t;

  exp_t q[$];

  seq_event_display #(.MODULUS(10), .DP_HOLD(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .det_in    (det_in),
    .clr_in    (clr_in),
    .hold_in   (hold_in),
    .seg_out   (seg_out),
    .count_out (count_out),
    .ovf_out   (ovf_out)
  );

  always #5 clk = ~clk;

  function automatic exp_t ex(input string n, input int cnt, input int ovf,
                              input int dp, input int seg7);
    exp_t e;
    e.name = n; e.cnt = cnt; e.ovf = ovf; e.dp = dp; e.seg7 = seg7;
    return e;
  endfunction

  // Drive one cycle; the expectation describes outputs after the next edge.
  task automatic cyc(input logic d, input logic c, input logic h, input exp_t e);
    det_in = d; clr_in = c; hold_in = h;
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  task automatic pulse(input logic h, input string n, input int cnt, input int seg7);
    cyc(1'b1, 1'b0, h, ex(n, cnt, -1, -1, seg7));
    cyc(1'b0, 1'b0, h, ex(n, cnt, -1, -1, seg7));
  endtask

  task automatic check(input string n, input string field, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s %s: got 'h%0h, expected 'h%0h", n, field, got, want);
    end
  endtask

  // Monitor: compares each queued expectation 2 time units after its edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.cnt  >= 0) check(e.name, "count_out", int'(count_out), e.cnt);
        if (e.ovf  >= 0) check(e.name, "ovf_out", int'(ovf_out), e.ovf);
        if (e.dp   >= 0) check(e.name, "dp", int'(seg_out[7]), e.dp);
        if (e.seg7 >= 0) check(e.name, "seg[6:0]", int'(seg_out[6:0]), e.seg7);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    cyc(1'b0, 1'b0, 1'b0, ex("reset", 0, 0, 0, 7'b0111111));
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, ex("post_reset", 0, 0, 0, 7'b0111111));

    // Long det_in level -> one event, 8-cycle dp, digit lags by one cycle
    cyc(1'b1, 1'b0, 1'b0, ex("single_evt", 1, 0, 1, 7'b0111111));
    for (int i = 2; i <= 5; i++) cyc(1'b1, 1'b0, 1'b0, ex("single_held", 1, 0, 1, 7'b0000110));
    for (int i = 6; i <= 8; i++) cyc(1'b0, 1'b0, 1'b0, ex("single_dp", 1, 0, 1, 7'b0000110));
    cyc(1'b0, 1'b0, 1'b0, ex("single_dp_end", 1, 0, 0, 7'b0000110));

    // Retrigger 3 cycles after the first event -> 11 dp cycles total
    cyc(1'b1, 1'b0, 1'b0, ex("retrig_evt1", 2, 0, 1, -1));
    cyc(1'b0, 1'b0, 1'b0, ex("retrig_dp", 2, 0, 1, -1));
    cyc(1'b0, 1'b0, 1'b0, ex("retrig_dp", 2, 0, 1, -1));
    cyc(1'b1, 1'b0, 1'b0, ex("retrig_evt2", 3, 0, 1, -1));
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0, ex("retrig_dp", 3, 0, 1, -1));
    cyc(1'b0, 1'b0, 1'b0, ex("retrig_dp_end", 3, 0, 0, 7'b1001111));

    // clr_in with a simultaneous det_in rise while flashing
    cyc(1'b1, 1'b0, 1'b0, ex("preclr_evt", 4, 0, 1, -1));
    cyc(1'b0, 1'b0, 1'b0, ex("preclr_dp", 4, 0, 1, -1));
    cyc(1'b1, 1'b1, 1'b0, ex("clr_evt", 0, 0, 0, -1));
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, ex("clr_held", 0, 0, 0, 7'b0111111));
    cyc(1'b0, 1'b0, 1'b0, ex("clr_release", 0, 0, 0, -1));

    // hold_in freezes the digit from count 2 while counting reaches 5
    pulse(1'b0, "hold_setup", 1, -1);
    pulse(1'b0, "hold_setup", 2, -1);
    cyc(1'b0, 1'b0, 1'b0, ex("hold_pre", 2, -1, -1, 7'b1011011));
    pulse(1'b1, "hold_frozen", 3, 7'b1011011);
    pulse(1'b1, "hold_frozen", 4, 7'b1011011);
    pulse(1'b1, "hold_frozen", 5, 7'b1011011);
    cyc(1'b0, 1'b0, 1'b0, ex("hold_release", 5, -1, -1, 7'b1101101));

    // Ten events with MODULUS=10: 9 -> 0 wrap with a single ovf pulse
    cyc(1'b0, 1'b1, 1'b0, ex("wrap_clr", 0, 0, -1, -1));
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b1, 1'b0, 1'b0, ex("wrap_evt", k % 10, (k == 10) ? 1 : 0, -1,
                               (k == 10) ? 7'b1101111 : -1));
      cyc(1'b0, 1'b0, 1'b0, ex("wrap_idle", k % 10, 0, -1,
                               (k == 10) ? 7'b0111111 : -1));
    end

    // Reset mid-flash at count 4, det_in high through reset release
    pulse(1'b0, "prerst", 1, -1);
    pulse(1'b0, "prerst", 2, -1);
    pulse(1'b0, "prerst", 3, -1);
    cyc(1'b1, 1'b0, 1'b0, ex("prerst_evt", 4, 0, 1, -1));
    cyc(1'b0, 1'b0, 1'b0, ex("prerst_dp", 4, 0, 1, 7'b1100110));
    #2;
    det_in = 1'b1;
    reset  = 1'b1;
    #3;
    reset  = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, ex("rst_mid", 0, 0, 0, 7'b0111111));
    cyc(1'b1, 1'b0, 1'b0, ex("rst_held", 0, 0, 0, 7'b0111111));
    cyc(1'b0, 1'b0, 1'b0, ex("rst_release", 0, 0, 0, 7'b0111111));

    repeat (3) @(posedge clk);
    #3;
    check("scoreboard", "pending", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
